// File: rtl/hilo_div_ctrl.sv
// HI/LO issue and writeback controller that sits in front of the 32-bit signed sequential divider.
// When `DIV_ZERO_TRAP_EN is defined, zero divisors are trapped instead of being launched.
module hilo_div_ctrl #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int COUNT_W        = 6
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done,
  output logic        timeout,
  output logic        div_by_zero,
  output logic        div_start,
  output logic [31:0] div_operand1,
  output logic [31:0] div_operand2,
  input  logic [63:0] div_result,
  input  logic        div_finish,
  input  logic        div_illegal
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  localparam logic [1:0]         OP_DIV      = 2'b00;
  localparam logic [1:0]         OP_MTHI     = 2'b01;
  localparam logic [1:0]         OP_MTLO     = 2'b10;
  localparam logic [COUNT_W-1:0] LP_CNT_LAST = COUNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [COUNT_W-1:0] LP_CNT_ONE  = COUNT_W'(1);

  state_t             r_state, w_state_nxt;
  logic [COUNT_W-1:0] r_count, w_count_nxt;
  logic [31:0]        r_hi, w_hi_nxt;
  logic [31:0]        r_lo, w_lo_nxt;
  logic [31:0]        r_op1, w_op1_nxt;
  logic [31:0]        r_op2, w_op2_nxt;
  logic               r_start, w_start_nxt;
  logic               r_done, w_done_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic               r_dbz, w_dbz_nxt;
  logic               w_accept;
  logic               w_trap;

`ifdef DIV_ZERO_TRAP_EN
  assign w_trap = (req_b == 32'd0);
`else
  logic w_unused_illegal;
  assign w_trap           = 1'b0;
  assign w_unused_illegal = div_illegal;
`endif

  assign w_accept     = req_valid & (r_state == S_IDLE);
  assign req_ready    = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign hi           = r_hi;
  assign lo           = r_lo;
  assign done         = r_done;
  assign timeout      = r_timeout;
  assign div_by_zero  = r_dbz;
  assign div_start    = r_start;
  assign div_operand1 = r_op1;
  assign div_operand2 = r_op2;

  // State register and all registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_op1     <= 32'd0;
      r_op2     <= 32'd0;
      r_start   <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_dbz     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
      r_op1     <= w_op1_nxt;
      r_op2     <= w_op2_nxt;
      r_start   <= w_start_nxt;
      r_done    <= w_done_nxt;
      r_timeout <= w_timeout_nxt;
      r_dbz     <= w_dbz_nxt;
    end
  end

  // Next-state and next-output logic; the pulse outputs default low
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    w_op1_nxt     = r_op1;
    w_op2_nxt     = r_op2;
    w_start_nxt   = 1'b0;
    w_done_nxt    = 1'b0;
    w_timeout_nxt = 1'b0;
    w_dbz_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (req_op)
            OP_DIV: begin
              if (w_trap) begin
                w_dbz_nxt = 1'b1;
              end else begin
                w_op1_nxt   = req_a;
                w_op2_nxt   = req_b;
                w_start_nxt = 1'b1;
                w_count_nxt = '0;
                w_state_nxt = S_LAUNCH;
              end
            end
            OP_MTHI: w_hi_nxt = req_a;
            OP_MTLO: w_lo_nxt = req_a;
            default: w_state_nxt = S_IDLE;
          endcase
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      // div_finish may still be high from the previous operation, so it is ignored here.
      S_LAUNCH: w_state_nxt = S_WAIT;
      S_WAIT: begin
        w_count_nxt = r_count + LP_CNT_ONE;
        // If finish and the timeout limit occur on the same cycle, finish takes priority.
        if (div_finish) begin
          w_hi_nxt    = div_result[63:32];
          w_lo_nxt    = div_result[31:0];
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
`ifdef DIV_ZERO_TRAP_EN
        else if (div_illegal) begin
          w_dbz_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
`endif
        else if (r_count == LP_CNT_LAST) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Self-checking bench for hilo_div_ctrl. It includes a behavioural model of the divider
// (configurable latency, no reset) and a reference model of the architectural HI/LO state.
module tb_hilo_div_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic        busy, done, timeout, div_by_zero, div_start;
  logic [31:0] hi, lo, div_operand1, div_operand2;
  logic [63:0] m_result = 64'd0;
  logic        m_finish = 1'b0;
  logic        m_illegal = 1'b0;
  int          m_lat = 33;
  int          m_cnt = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  hilo_div_ctrl dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .busy(busy), .hi(hi), .lo(lo),
    .done(done), .timeout(timeout), .div_by_zero(div_by_zero), .div_start(div_start),
    .div_operand1(div_operand1), .div_operand2(div_operand2), .div_result(m_result),
    .div_finish(m_finish), .div_illegal(m_illegal)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end
    return {r, q};
  endfunction

  // Divider model: samples start, reads operands live, and raises finish m_lat edges later.
  always @(posedge clock) begin
    if (div_start) begin
      m_cnt    <= 1;
      m_finish <= 1'b0;
    end else if (m_cnt != 0) begin
      if (m_cnt == m_lat - 1) begin
        m_finish <= 1'b1;
        m_result <= ref_div(div_operand1, div_operand2);
        m_cnt    <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issues one DIV and records what was observed while the controller was busy.
  task automatic issue_div(input logic [31:0] a, input logic [31:0] b,
                           output int nbusy, output int nstart, output int nbad,
                           output int nhold, output int nrdy, output logic fdone,
                           output logic fto, output logic fdbz);
    nbusy = 0; nstart = 0; nbad = 0; nhold = 0; nrdy = 0;
    req_valid = 1'b1; req_op = 2'b00; req_a = a; req_b = b;
    tick();
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom;
    while (busy === 1'b1 && nbusy < 200) begin
      nbusy++;
      if (div_start) nstart++;
      if (done || timeout || div_by_zero) nbad++;
      if (div_operand1 !== a || div_operand2 !== b) nhold++;
      if (req_ready) nrdy++;
      tick();
    end
    fdone = done; fto = timeout; fdbz = div_by_zero;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({hi, lo, div_operand1, div_operand2} !== 128'd0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {hi, lo, div_operand1, div_operand2});
    end
    checks++;
    if ({busy, req_ready, div_start, done, timeout, div_by_zero} !== 6'b010000) begin
      failures++; $display("FAIL reset_flags got=%b exp=010000", {busy, req_ready, div_start, done, timeout, div_by_zero});
    end
    @(negedge clock); reset_n = 1'b1;
    tick();
  endtask

  task automatic test_div_basic();
    int nb, ns, nbad, nh, nr;
    logic fd, ft, fz;
    issue_div(32'd100, 32'hFFFF_FFF9, nb, ns, nbad, nh, nr, fd, ft, fz);
    checks++; if (nb !== 34) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=34", nb); end
    checks++; if (ns !== 1) begin failures++; $display("FAIL basic_start_pulses got=%0d exp=1", ns); end
    checks++; if (nbad !== 0 || nh !== 0 || nr !== 0) begin
      failures++; $display("FAIL basic_during_busy early_pulse=%0d op_changed=%0d ready=%0d exp=0", nbad, nh, nr);
    end
    checks++; if (fd !== 1'b1 || ft !== 1'b0) begin failures++; $display("FAIL basic_done got=%b%b exp=10", fd, ft); end
    checks++; if ({hi, lo} !== 64'h00000002_FFFFFFF2) begin
      failures++; $display("FAIL basic_hilo got=%h exp=00000002fffffff2", {hi, lo});
    end
    exp_hi = 32'h0000_0002; exp_lo = 32'hFFFF_FFF2;
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_once got=%b exp=0", done); end
  endtask

  task automatic test_back_to_back();
    int n, rdy, hold;
    logic [31:0] a2, b2;
    logic [63:0] r2;
    a2 = $urandom; b2 = $urandom_range(1, 1000);
    r2 = ref_div(a2, b2);
    n = 0; rdy = 0; hold = 0;
    req_valid = 1'b1; req_op = 2'b00; req_a = 32'hFFFF_FF9C; req_b = 32'd7;
    tick();
    req_a = a2; req_b = b2;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (req_ready) rdy++;
      if (div_operand1 !== 32'hFFFF_FF9C || div_operand2 !== 32'd7) hold++;
      tick();
    end
    checks++; if (n !== 34 || rdy !== 0 || hold !== 0) begin
      failures++; $display("FAIL b2b_first_busy cycles=%0d ready=%0d op_changed=%0d exp=34/0/0", n, rdy, hold);
    end
    checks++; if ({done, req_ready, hi, lo} !== {2'b11, 64'hFFFFFFFE_FFFFFFF2}) begin
      failures++; $display("FAIL b2b_first_result got=%b%b %h exp=11 fffffffefffffff2", done, req_ready, {hi, lo});
    end
    tick();
    req_valid = 1'b0;
    checks++; if ({busy, div_start, div_operand1, div_operand2} !== {2'b11, a2, b2}) begin
      failures++; $display("FAIL b2b_second_accept got=%b%b %h %h exp=11 %h %h", busy, div_start, div_operand1, div_operand2, a2, b2);
    end
    n = 0;
    while (busy === 1'b1 && n < 200) begin n++; tick(); end
    checks++; if (n !== 34 || done !== 1'b1 || {hi, lo} !== r2) begin
      failures++; $display("FAIL b2b_second_result cycles=%0d done=%b got=%h exp=34 1 %h", n, done, {hi, lo}, r2);
    end
    exp_hi = r2[63:32]; exp_lo = r2[31:0];
    tick();
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] junk;
    req_valid = 1'b1; req_op = 2'b01; req_a = 32'h1234_5678;
    tick();
    checks++; if ({busy, hi, lo} !== {1'b0, 32'h1234_5678, exp_lo}) begin
      failures++; $display("FAIL mthi got=%b %h %h exp=0 12345678 %h", busy, hi, lo, exp_lo);
    end
    req_op = 2'b10; req_a = 32'hCAFE_BABE;
    tick();
    checks++; if ({busy, hi, lo} !== {1'b0, 32'h1234_5678, 32'hCAFE_BABE}) begin
      failures++; $display("FAIL mtlo got=%b %h %h exp=0 12345678 cafebabe", busy, hi, lo);
    end
    exp_hi = 32'h1234_5678; exp_lo = 32'hCAFE_BABE;
    junk = $urandom; req_op = 2'b11; req_a = junk; req_b = junk;
    tick();
    req_valid = 1'b0;
    checks++; if ({busy, req_ready, div_start, hi, lo} !== {3'b010, exp_hi, exp_lo}) begin
      failures++; $display("FAIL reserved_op got=%b%b%b %h %h exp=010 %h %h", busy, req_ready, div_start, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset_mid_div();
    int nb, ns, nbad, nh, nr, ndone;
    logic fd, ft, fz;
    req_valid = 1'b1; req_op = 2'b00; req_a = 32'd1000; req_b = 32'd3;
    tick();
    req_valid = 1'b0;
    repeat (11) tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midreset_busy_before got=%b exp=1", busy); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({busy, div_start, hi, lo, div_operand1} !== {2'b00, 96'd0}) begin
      failures++; $display("FAIL midreset_state got=%b%b %h %h %h exp=00 0 0 0", busy, div_start, hi, lo, div_operand1);
    end
    @(negedge clock); reset_n = 1'b1;
    exp_hi = 32'd0; exp_lo = 32'd0;
    ndone = 0;
    repeat (40) begin tick(); if (done || busy) ndone++; end
    checks++; if ({hi, lo} !== 64'd0 || ndone !== 0 || m_finish !== 1'b1) begin
      failures++; $display("FAIL midreset_stale_finish got=%h activity=%0d finish=%b exp=0 0 1", {hi, lo}, ndone, m_finish);
    end
    issue_div(32'd9, 32'd2, nb, ns, nbad, nh, nr, fd, ft, fz);
    checks++; if (nb !== 34 || fd !== 1'b1 || {hi, lo} !== {32'd1, 32'd4}) begin
      failures++; $display("FAIL midreset_new_div cycles=%0d done=%b got=%h exp=34 1 0000000100000004", nb, fd, {hi, lo});
    end
    exp_hi = 32'd1; exp_lo = 32'd4;
    tick();
  endtask

  task automatic test_timeout();
    int nb, ns, nbad, nh, nr;
    logic fd, ft, fz;
    logic [63:0] r;
    m_lat = 1000;
    issue_div($urandom, 32'd5, nb, ns, nbad, nh, nr, fd, ft, fz);
    checks++; if (nb !== 41 || ft !== 1'b1 || fd !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL timeout_hang cycles=%0d to=%b done=%b ready=%b exp=41 1 0 1", nb, ft, fd, req_ready);
    end
    checks++; if ({hi, lo} !== {exp_hi, exp_lo}) begin
      failures++; $display("FAIL timeout_hilo got=%h exp=%h", {hi, lo}, {exp_hi, exp_lo});
    end
    tick();
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL timeout_once got=%b exp=0", timeout); end
    // finish arriving on the last allowed cycle wins over the timeout
    m_lat = 40;
    r = ref_div(32'd77, 32'd10);
    issue_div(32'd77, 32'd10, nb, ns, nbad, nh, nr, fd, ft, fz);
    checks++; if (nb !== 41 || fd !== 1'b1 || ft !== 1'b0 || {hi, lo} !== r) begin
      failures++; $display("FAIL finish_at_limit cycles=%0d done=%b to=%b got=%h exp=41 1 0 %h", nb, fd, ft, {hi, lo}, r);
    end
    exp_hi = r[63:32]; exp_lo = r[31:0];
    tick();
    m_lat = 41;
    issue_div(32'd55, 32'd4, nb, ns, nbad, nh, nr, fd, ft, fz);
    checks++; if (nb !== 41 || ft !== 1'b1 || fd !== 1'b0 || {hi, lo} !== {exp_hi, exp_lo}) begin
      failures++; $display("FAIL finish_past_limit cycles=%0d to=%b done=%b got=%h exp=41 1 0 %h", nb, ft, fd, {hi, lo}, {exp_hi, exp_lo});
    end
    tick();
    m_lat = 33;
  endtask

  task automatic test_div_zero();
`ifdef DIV_ZERO_TRAP_EN
    req_valid = 1'b1; req_op = 2'b00; req_a = 32'd7; req_b = 32'd0;
    tick();
    req_valid = 1'b0;
    checks++; if ({div_by_zero, div_start, busy, hi, lo} !== {3'b100, exp_hi, exp_lo}) begin
      failures++; $display("FAIL dbz_trap got=%b%b%b %h %h exp=100 %h %h", div_by_zero, div_start, busy, hi, lo, exp_hi, exp_lo);
    end
    tick();
    checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL dbz_once got=%b exp=0", div_by_zero); end
`else
    int nb, ns, nbad, nh, nr;
    logic fd, ft, fz;
    issue_div(32'd7, 32'd0, nb, ns, nbad, nh, nr, fd, ft, fz);
    checks++; if (nb !== 34 || fd !== 1'b1 || fz !== 1'b0 || {hi, lo} !== 64'h00000007_FFFFFFFF) begin
      failures++; $display("FAIL div_zero_launch cycles=%0d done=%b dbz=%b got=%h exp=34 1 0 00000007ffffffff", nb, fd, fz, {hi, lo});
    end
    exp_hi = 32'd7; exp_lo = 32'hFFFF_FFFF;
    tick();
`endif
  endtask

  task automatic test_random();
    int nb, ns, nbad, nh, nr;
    logic fd, ft, fz;
    logic [31:0] a, b;
    logic [1:0] op;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if (op == 2'b00) begin
        if (b == 32'd0) b = 32'd3;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
        m_lat = $urandom_range(33, 38);
        issue_div(a, b, nb, ns, nbad, nh, nr, fd, ft, fz);
        exp_lo = 32'($signed(a) / $signed(b));
        exp_hi = 32'($signed(a) % $signed(b));
        checks++; if (nb !== m_lat + 1 || ns !== 1 || fd !== 1'b1 || {hi, lo} !== {exp_hi, exp_lo}) begin
          failures++; $display("FAIL rand_div a=%h b=%h cycles=%0d starts=%0d done=%b got=%h exp=%0d 1 1 %h", a, b, nb, ns, fd, {hi, lo}, m_lat + 1, {exp_hi, exp_lo});
        end
      end else begin
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        tick();
        req_valid = 1'b0;
        if (op == 2'b01) exp_hi = a;
        else if (op == 2'b10) exp_lo = a;
        checks++; if ({busy, hi, lo} !== {1'b0, exp_hi, exp_lo}) begin
          failures++; $display("FAIL rand_move op=%0d got=%b %h %h exp=0 %h %h", op, busy, hi, lo, exp_hi, exp_lo);
        end
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    m_lat = 33;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_div_basic();
    test_back_to_back();
    test_mthi_mtlo();
    test_reset_mid_div();
    test_timeout();
    test_div_zero();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_div_ctrl.md
Name: hilo_div_ctrl

Overview:
- Issue/writeback controller directly upstream and downstream of the 32-bit signed sequential divider.
- Accepts divide and move-to-HI/LO requests from the execute stage and launches the divider with a one-cycle start pulse.
- Holds the divider's operands stable for the whole operation, waits for finish, and captures the 64-bit result into architectural HI (remainder) and LO (quotient).
- Stalls the pipeline via busy while a division is in flight.

Parameters:
- TIMEOUT_CYCLES, 40, WAIT-state cycle limit before aborting; must exceed divider latency (33).
- COUNT_W, 6, width of the WAIT cycle counter; must satisfy 2^COUNT_W > TIMEOUT_CYCLES.

Ports:
- clock  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept (high only in IDLE)
- req_op  input  2  00 DIV, 01 MTHI, 10 MTLO, 11 reserved (accepted, no effect)
- req_a  input  32  dividend / MTHI-MTLO data
- req_b  input  32  divisor
- busy  output  1  division in flight; pipeline must stall HI/LO readers
- hi  output  32  HI register (remainder)
- lo  output  32  LO register (quotient)
- done  output  1  one-cycle pulse when HI/LO are written by a division
- timeout  output  1  one-cycle pulse when a division is aborted
- div_by_zero  output  1  one-cycle pulse on trapped divide-by-zero (see Optional Feature)
- div_start  output  1  start pulse to divider
- div_operand1  output  32  dividend to divider
- div_operand2  output  32  divisor to divider
- div_result  input  64  divider result, [63:32] remainder, [31:0] quotient
- div_finish  input  1  divider completion level
- div_illegal  input  1  divider zero-divisor flag (used only with the macro)

Behaviour:
- Reset (async, reset_n=0): state=IDLE. hi, lo, div_operand1, div_operand2 = 0. div_start, done, timeout, div_by_zero = 0. Counter = 0.
  - A reset mid-division abandons the operation; HI/LO are not written.
  - The divider itself has no reset; its stale div_finish is ignored outside WAIT.
- Accept: a request is accepted at a rising edge when req_valid & req_ready. req_ready = (state==IDLE). busy = (state!=IDLE).
- IDLE:
  - MTHI: hi<=req_a at the accept edge; stay IDLE.
  - MTLO: lo<=req_a at the accept edge; stay IDLE.
  - Reserved op: accepted, no effect.
  - DIV: div_operand1<=req_a, div_operand2<=req_b, div_start<=1, counter<=0, go LAUNCH.
- LAUNCH (exactly 1 cycle): div_start=1. div_finish is ignored here because it may still be high from the previous op. Next edge: div_start<=0, go WAIT.
- WAIT:
  - div_start=0. div_operand1/2 are held unchanged, since the divider reads them live for its sign fix-up.
  - Counter increments each cycle.
  - If div_finish=1: hi<=div_result[63:32], lo<=div_result[31:0], done<=1 for one cycle, go IDLE.
  - Else if counter==TIMEOUT_CYCLES-1: timeout<=1 for one cycle, HI/LO unchanged, go IDLE.
- Latency: accept edge E0; divider samples start at E1; div_finish rises after E33; HI/LO are written at E34. busy is high from after E0 through E34.
- req_valid while busy: not accepted; the requester holds the request. Back-to-back DIV is accepted in the cycle after done (IDLE).
- A simultaneous div_finish and timeout condition resolves to finish (result written, no timeout).
- No arithmetic is performed locally; the result is copied verbatim.

Optional Feature:
- Macro: DIV_ZERO_TRAP_EN.
- Defined:
  - A DIV with req_b==0 is accepted but not launched (div_start stays 0).
  - div_by_zero pulses 1 cycle after the accept edge; HI/LO unchanged; state stays IDLE.
  - div_illegal is also checked in WAIT: if high, abort as for timeout but pulse div_by_zero instead.
- Undefined:
  - The zero divisor is launched normally and the divider's output is written.
  - div_by_zero is tied 0; div_illegal is unused.

Test Plan:
- Reset, then DIV a=100, b=0xFFFFFFF9 (-7) -> after 34 edges lo=0xFFFFFFF2, hi=0x00000002, done pulses once; busy high 34 cycles.
- DIV a=0xFFFFFF9C (-100), b=7 -> lo=0xFFFFFFF2, hi=0xFFFFFFFE; req_valid held during busy is not accepted until the cycle after done.
- MTHI 0x12345678, then MTLO 0xCAFEBABE on consecutive cycles -> hi/lo update at each accept edge, busy stays 0.
- Assert reset_n=0 at WAIT cycle 10 -> immediate IDLE, hi=lo=0, div_start=0; a new DIV 9/2 then yields lo=4, hi=1.
- Model the divider with div_finish held low -> timeout pulses after 40 WAIT cycles, HI/LO unchanged, req_ready=1.
- DIV 7/0: with DIV_ZERO_TRAP_EN -> div_by_zero pulse, no div_start, HI/LO unchanged; without it -> lo=0xFFFFFFFF, hi=0x00000007.
